// File: rtl/command_executor_pkg.sv
// Shared types for the terminal command executor: command codes, FSM states,
// default screen geometry and a clamping helper for cursor arithmetic.
package DataType;

  localparam int ROWS_DEF = 24;
  localparam int COLS_DEF = 80;
  localparam int ROW_W    = 5;
  localparam int COL_W    = 7;

  typedef enum logic [3:0] {
    INPUT = 4'd0,
    CUU   = 4'd1,
    CUD   = 4'd2,
    CUF   = 4'd3,
    CUB   = 4'd4,
    CUP   = 4'd5,
    IND   = 4'd6,
    NEL   = 4'd7,
    RI    = 4'd8
  } CommandsType;

  // IDLE pop queue | DECODE act on command | WRITE RAM handshake | ADVANCE step column | SCROLL wait done
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    WRITE   = 3'd2,
    ADVANCE = 3'd3,
    SCROLL  = 3'd4
  } ExecState;

  typedef struct packed {
    CommandsType cmd_type;
    logic [7:0]  pn1;
    logic [7:0]  pn2;
    logic [7:0]  pchar;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Signed width leaves headroom for row/col +/- 255, so clamping never sees a wrapped value.
  function automatic logic [6:0] clamp_pos(input logic signed [9:0] v,
                                           input logic signed [9:0] hi);
    logic [6:0] r;
    if (v < 0)       r = 7'd0;
    else if (v > hi) r = hi[6:0];
    else             r = v[6:0];
    return r;
  endfunction

endpackage

// File: rtl/command_executor_cmd_fifo.sv
// Two-entry command queue; a push is accepted while full if a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/command_executor.sv
// Terminal command executor: queues parser commands, moves the cursor, writes characters and requests scrolls.
// Optional EXECUTOR_AUTOWRAP_EN: a write in the last column wraps to column 0 of the next line.
module command_executor
  import DataType::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  CommandsType cmd_type,
  input  logic [7:0]  pn1,
  input  logic [7:0]  pn2,
  input  logic [7:0]  pchar,
  output logic        busy,
  output logic        wr_req,
  input  logic        wr_ready,
  output logic [4:0]  wr_row,
  output logic [6:0]  wr_col,
  output logic [7:0]  wr_char,
  output logic        scroll_req,
  input  logic        scroll_done,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col
);

  localparam logic signed [9:0] ROW_MAX  = 10'(ROWS - 1);
  localparam logic signed [9:0] COL_MAX  = 10'(COLS - 1);
  localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0]        COL_LAST = 7'(COLS - 1);

  ExecState          state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [4:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic              wr_req_q, wr_req_d;
  logic [4:0]        wr_row_q, wr_row_d;
  logic [6:0]        wr_col_q, wr_col_d;
  logic [7:0]        wr_char_q, wr_char_d;
  logic              scroll_req_q, scroll_req_d;

  cmd_t              fifo_head;
  cmd_t              fifo_in;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic              do_ind;
  logic signed [9:0] step;
  logic signed [9:0] row_s;
  logic signed [9:0] col_s;

  assign fifo_in = '{cmd_type: cmd_type, pn1: pn1, pn2: pn2, pchar: pchar};

  cmd_fifo #(.WIDTH(CMD_W)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign step  = (cmd_q.pn1 == 8'd0) ? 10'sd1 : $signed({2'b00, cmd_q.pn1});
  assign row_s = $signed({5'b00000, row_q});
  assign col_s = $signed({3'b000, col_q});

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    row_d        = row_q;
    col_d        = col_q;
    wr_req_d     = wr_req_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_char_d    = wr_char_q;
    scroll_req_d = scroll_req_q;
    fifo_pop     = 1'b0;
    do_ind       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        case (cmd_q.cmd_type)
          INPUT: begin
            if (cmd_q.pchar >= 8'h20) begin
              state_d   = WRITE;
              wr_req_d  = 1'b1;
              wr_row_d  = row_q;
              wr_col_d  = col_q;
              wr_char_d = cmd_q.pchar;
            end else if (cmd_q.pchar == 8'h0D) begin
              col_d = '0;
            end else if (cmd_q.pchar == 8'h0A) begin
              do_ind = 1'b1;
            end else if (cmd_q.pchar == 8'h08) begin
              col_d = clamp_pos(col_s - 10'sd1, COL_MAX);
            end
          end
          CUU:     row_d = 5'(clamp_pos(row_s - step, ROW_MAX));
          CUD:     row_d = 5'(clamp_pos(row_s + step, ROW_MAX));
          CUF:     col_d = clamp_pos(col_s + step, COL_MAX);
          CUB:     col_d = clamp_pos(col_s - step, COL_MAX);
          CUP: begin
            // pn-1 with pn=0 goes negative and clamps to 0, giving max(pn,1)-1
            row_d = 5'(clamp_pos($signed({2'b00, cmd_q.pn1}) - 10'sd1, ROW_MAX));
            col_d = clamp_pos($signed({2'b00, cmd_q.pn2}) - 10'sd1, COL_MAX);
          end
          IND:     do_ind = 1'b1;
          NEL: begin
            col_d  = '0;
            do_ind = 1'b1;
          end
          RI:      row_d = 5'(clamp_pos(row_s - 10'sd1, ROW_MAX));
          default: ;
        endcase
      end
      WRITE: begin
        if (wr_ready) begin
          wr_req_d = 1'b0;
          state_d  = ADVANCE;
        end
      end
      ADVANCE: begin
        state_d = IDLE;
        if (col_q != COL_LAST) col_d = col_q + 7'd1;
`ifdef EXECUTOR_AUTOWRAP_EN
        else begin
          col_d  = '0;
          do_ind = 1'b1;
        end
`endif
      end
      SCROLL: begin
        if (scroll_done) begin
          scroll_req_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_ind) begin
      if (row_q == ROW_LAST) begin
        state_d      = SCROLL;
        scroll_req_d = 1'b1;
      end else begin
        row_d = row_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      wr_req_q     <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_char_q    <= '0;
      scroll_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wr_req_q     <= wr_req_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_char_q    <= wr_char_d;
      scroll_req_q <= scroll_req_d;
    end
  end

  assign busy       = fifo_full;
  assign wr_req     = wr_req_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_char    = wr_char_q;
  assign scroll_req = scroll_req_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule
